seq_divider: RTL and testbench

- Parametrised multi-cycle integer divider.
- Computes quotient and remainder of a DW-bit dividend by a DW-bit divisor, one restoring shift-subtract iteration per clock.
- Both operands are run-time inputs captured on a start handshake; optional signed mode.
- Sits as a shared arithmetic unit behind a controller that issues start_i and waits for done_o.

---
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_divider.sv | 120 ++++++++++++
 tb/tb_seq_divider.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/result handshake between a controller and the sequential divider.
interface seq_divider_if #(
    parameter int DW = 8
);
    logic          start_i;
    logic [DW-1:0] dividend_i;
    logic [DW-1:0] divisor_i;
    logic          ready_o;
    logic          busy_o;
    logic          done_o;
    logic [DW-1:0] quotient_o;
    logic [DW-1:0] remainder_o;
    logic          dbz_o;

    modport master (
        output start_i, dividend_i, divisor_i,
        input  ready_o, busy_o, done_o,
        input  quotient_o, remainder_o, dbz_o
    );

    modport slave (
        input  start_i, dividend_i, divisor_i,
        output ready_o, busy_o, done_o,
        output quotient_o, remainder_o, dbz_o
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// Optional two's-complement mode divides magnitudes and fixes signs at the end.
module seq_divider #(
    parameter int DW     = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_divider_if.slave    bus
);
    localparam int CW = $clog2(DW) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [DW-1:0] dvs_q, dvs_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [DW-1:0] rmd_q, rmd_d;
    logic          dbz_q, dbz_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          a_neg, b_neg;
    logic [DW-1:0] a_mag, b_mag;
    logic [DW:0]   shl, diff;
    logic [DW-1:0] rem_nx, quo_nx;

    always_comb begin
        a_neg  = SIGNED && bus.dividend_i[DW-1];
        b_neg  = SIGNED && bus.divisor_i[DW-1];
        a_mag  = a_neg ? -bus.dividend_i : bus.dividend_i;
        b_mag  = b_neg ? -bus.divisor_i : bus.divisor_i;
        shl    = {rem_q, dvd_q[DW-1]};
        diff   = shl - {1'b0, dvs_q};
        rem_nx = diff[DW] ? shl[DW-1:0] : diff[DW-1:0];
        quo_nx = {dvd_q[DW-2:0], ~diff[DW]};

        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    // A zero divisor keeps the raw dividend for the remainder
                    dvs_d   = b_mag;
                    dvd_d   = (bus.divisor_i == '0) ? bus.dividend_i : a_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dvs_q == '0) begin
                    quo_d   = '1;
                    rmd_d   = dvd_q;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    rem_d = rem_nx;
                    dvd_d = quo_nx;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DW - 1)) begin
                        quo_d   = qneg_q ? -quo_nx : quo_nx;
                        rmd_d   = rneg_q ? -rem_nx : rem_nx;
                        dbz_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ready_o     = (state_q == IDLE);
    assign bus.busy_o      = (state_q == RUN);
    assign bus.done_o      = (state_q == DONE);
    assign bus.quotient_o  = quo_q;
    assign bus.remainder_o = rmd_q;
    assign bus.dbz_o       = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Lockstep check of unsigned and signed divider instances against a
// reference model scoreboard.
module tb_seq_divider;
    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          dbz;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] a_r = '0;
    logic [DW-1:0] b_r = '0;

    int   checks = 0;
    int   errors = 0;
    exp_t qu[$];
    exp_t qs[$];
    exp_t pu = '0;
    exp_t ps = '0;

    seq_divider_if #(.DW(DW)) ifu ();
    seq_divider_if #(.DW(DW)) ifs ();

    assign ifu.start_i    = start;
    assign ifu.dividend_i = a_r;
    assign ifu.divisor_i  = b_r;
    assign ifs.start_i    = start;
    assign ifs.dividend_i = a_r;
    assign ifs.divisor_i  = b_r;

    seq_divider #(.DW(DW), .SIGNED(1'b0)) u_u (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifu)
    );

    seq_divider #(.DW(DW), .SIGNED(1'b1)) u_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mu(input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        if (b == 0) e = '{q: '1, r: a, dbz: 1'b1};
        else e = '{q: a / b, r: a % b, dbz: 1'b0};
        return e;
    endfunction

    function automatic exp_t ms(input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        int   sa, sb, q, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            e = '{q: '1, r: a, dbz: 1'b1};
        end else begin
            q = sa / sb;
            r = sa % sb;
            e = '{q: q[DW-1:0], r: r[DW-1:0], dbz: 1'b0};
        end
        return e;
    endfunction

    task automatic chk_outs(input string tag, input exp_t eu, input exp_t es);
        chk({tag, ".u.q"}, 32'(ifu.quotient_o), 32'(eu.q));
        chk({tag, ".u.r"}, 32'(ifu.remainder_o), 32'(eu.r));
        chk({tag, ".u.dbz"}, 32'(ifu.dbz_o), 32'(eu.dbz));
        chk({tag, ".s.q"}, 32'(ifs.quotient_o), 32'(es.q));
        chk({tag, ".s.r"}, 32'(ifs.remainder_o), 32'(es.r));
        chk({tag, ".s.dbz"}, 32'(ifs.dbz_o), 32'(es.dbz));
    endtask

    // Issue one division, optionally pulsing ignored starts mid-run.
    task automatic op(input string tag, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input bit pulse);
        int   n;
        int   nbusy;
        bit   held;
        bit   seen;
        exp_t eu, es;
        n = 0;
        while (!ifu.ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready"}, 32'(ifu.ready_o && ifs.ready_o), 32'd1);
        a_r   = a;
        b_r   = b;
        start = 1'b1;
        qu.push_back(mu(a, b));
        qs.push_back(ms(a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        a_r   = DW'($urandom);
        b_r   = DW'($urandom);
        n     = 0;
        nbusy = 0;
        held  = 1'b1;
        seen  = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (ifu.done_o) begin
                seen = 1'b1;
            end else begin
                if (ifu.busy_o) nbusy++;
                if (ifu.quotient_o !== pu.q || ifu.remainder_o !== pu.r ||
                    ifs.quotient_o !== ps.q || ifs.remainder_o !== ps.r)
                    held = 1'b0;
                start = pulse && (n == 3 || n == 7);
                if (start) begin
                    a_r = 8'd100;
                    b_r = 8'd10;
                end
            end
        end
        start = 1'b0;
        chk({tag, ".done_seen"}, 32'(seen), 32'd1);
        chk({tag, ".latency"}, 32'(n - 1), (b == 0) ? 32'd1 : 32'(DW));
        chk({tag, ".busy_cycles"}, 32'(nbusy), (b == 0) ? 32'd1 : 32'(DW));
        chk({tag, ".held"}, 32'(held), 32'd1);
        chk({tag, ".lockstep"}, 32'(ifs.done_o), 32'd1);
        eu = qu.pop_front();
        es = qs.pop_front();
        chk_outs(tag, eu, es);
        pu = eu;
        ps = es;
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(ifu.done_o || ifs.done_o), 32'd0);
    endtask

    initial begin
        bit saw_done;
        repeat (3) @(negedge clk);
        chk("rst.ready", 32'(ifu.ready_o && ifs.ready_o), 32'd1);
        chk("rst.busy", 32'(ifu.busy_o || ifs.busy_o), 32'd0);
        chk("rst.done", 32'(ifu.done_o || ifs.done_o), 32'd0);
        chk_outs("rst", '0, '0);
        rst_n = 1'b1;
        @(negedge clk);

        op("u17_5", 8'd17, 8'd5, 1'b0);
        op("u255_1", 8'd255, 8'd1, 1'b0);
        op("u3_200", 8'd3, 8'd200, 1'b0);
        op("dbz7", 8'd7, 8'd0, 1'b0);
        op("u9_3", 8'd9, 8'd3, 1'b0);
        op("ign17_5", 8'd17, 8'd5, 1'b1);
        op("b2b40_6", 8'd40, 8'd6, 1'b0);
        op("sm17_5", 8'hEF, 8'd5, 1'b0);
        chk("sm17_5.const", 32'({ifs.quotient_o, ifs.remainder_o}), 32'hFDFE);
        op("s17_m5", 8'd17, 8'hFB, 1'b0);
        chk("s17_m5.const", 32'({ifs.quotient_o, ifs.remainder_o}), 32'hFD02);
        op("sm128_m1", 8'h80, 8'hFF, 1'b0);
        chk("sm128_m1.const", 32'({ifs.quotient_o, ifs.remainder_o, ifs.dbz_o}),
            32'h10000);
        op("sm100_0", 8'h9C, 8'd0, 1'b0);

        // Abort a run with an asynchronous reset mid-cycle
        a_r   = 8'd50;
        b_r   = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.ready", 32'(ifu.ready_o && ifs.ready_o), 32'd1);
        chk("abort.busy", 32'(ifu.busy_o || ifs.busy_o), 32'd0);
        chk_outs("abort", '0, '0);
        pu = '0;
        ps = '0;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ifu.done_o || ifs.done_o) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ifu.done_o || ifs.done_o) saw_done = 1'b1;
        end
        chk("abort.no_done", 32'(saw_done), 32'd0);
        op("u20_6", 8'd20, 8'd6, 1'b0);

        for (int i = 0; i < 6; i++) begin
            op("rand", DW'($urandom), DW'($urandom_range(0, 255)), 1'b0);
        end

        chk("sb.empty", 32'(qu.size() + qs.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
